// File: rtl/fixed_to_fp_arbiter_if.sv
// Bus between NUM_REQ fixed-point producers, the shared converter block and the FP output consumer.
// The block uses the slave view; producers/consumer (or a bench) use the master view.
interface fixed_to_fp_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
);
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ-1:0]    req_sign_i;
  logic [NUM_REQ-1:0]    req_integer_i;
  logic [NUM_REQ*19-1:0] req_frac_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic                  fp_valid_o;
  logic [31:0]           fp_o;
  logic [ID_W-1:0]       fp_id_o;
  logic                  fp_range_err_o;
  logic                  fp_ready_i;
  logic [CNT_W-1:0]      conv_count_o;

  modport slave (
    input  req_valid_i, req_sign_i, req_integer_i, req_frac_i, fp_ready_i,
    output req_ready_o, fp_valid_o, fp_o, fp_id_o, fp_range_err_o, conv_count_o
  );

  modport master (
    output req_valid_i, req_sign_i, req_integer_i, req_frac_i, fp_ready_i,
    input  req_ready_o, fp_valid_o, fp_o, fp_id_o, fp_range_err_o, conv_count_o
  );
endinterface

// File: rtl/fixed_to_fp_arbiter.sv
// Round-robin sharing of one combinational Q1.19 (sign/int/frac) to IEEE-754 converter,
// with a one-deep registered result stage on a valid/ready output.
module fixed_to_fp_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  fixed_to_fp_arbiter_if.slave   bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  // Returns {range_err, fp32}; integer bit saturates to +/-1.0, no rounding needed since 19 bits fit in 23.
  function automatic logic [32:0] fixed_to_fp(input logic sign, input logic int_bit, input logic [18:0] frac);
    logic [4:0]  p;
    logic [18:0] sh;
    logic [7:0]  exp_v;
    logic [32:0] res;
    p = 5'd0;
    for (int i = 0; i < 19; i++) begin
      p = frac[i] ? 5'(19 - i) : p;
    end
    sh    = frac << p;
    exp_v = 8'd127 - {3'd0, p};
    if (int_bit) begin
      res = {(frac != 19'd0), sign, 8'd127, 23'd0};
    end else if (frac == 19'd0) begin
      res = 33'd0;
    end else begin
      res = {1'b0, sign, exp_v, sh, 4'd0};
    end
    return res;
  endfunction

  state_t              state_r, state_nxt_s;
  logic [ID_W-1:0]     rr_r;
  logic [31:0]         fp_r;
  logic [ID_W-1:0]     fp_id_r;
  logic                fp_err_r;
  logic [CNT_W-1:0]    conv_count_r;

  logic                can_accept_s;
  logic                found_s;
  logic                accept_s;
  logic [ID_W-1:0]     grant_s;
  logic [ID_W-1:0]     cand_s;
  logic [NUM_REQ-1:0]  req_ready_s;
  logic [32:0]         conv_s;

  assign can_accept_s = (state_r == EMPTY) | bus.fp_ready_i;
  assign accept_s     = found_s & can_accept_s;

  // Round-robin search from rr_r, first valid requester wins.
  always_comb begin
    found_s     = 1'b0;
    grant_s     = '0;
    cand_s      = '0;
    req_ready_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = ID_W'((int'(rr_r) + k) % NUM_REQ);
      if (!found_s && bus.req_valid_i[cand_s]) begin
        found_s = 1'b1;
        grant_s = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    if (accept_s) begin
      req_ready_s[grant_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  // Converter fed from the granted requester.
  always_comb begin
    conv_s = fixed_to_fp(bus.req_sign_i[grant_s], bus.req_integer_i[grant_s],
                         bus.req_frac_i[int'(grant_s)*19 +: 19]);
  end

  // Output-stage next state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY:   state_nxt_s = accept_s ? FULL : EMPTY;
      FULL: begin
        if (accept_s) begin
          state_nxt_s = FULL;
        end else if (bus.fp_ready_i) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // State, pointer and result registers; payload only changes on accept so a stall holds it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= EMPTY;
      rr_r         <= '0;
      fp_r         <= 32'd0;
      fp_id_r      <= '0;
      fp_err_r     <= 1'b0;
      conv_count_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        rr_r         <= ID_W'((int'(grant_s) + 1) % NUM_REQ);
        fp_r         <= conv_s[31:0];
        fp_err_r     <= conv_s[32];
        fp_id_r      <= grant_s;
        conv_count_r <= conv_count_r + CNT_W'(1);
      end else begin
        rr_r         <= rr_r;
        fp_r         <= fp_r;
        fp_err_r     <= fp_err_r;
        fp_id_r      <= fp_id_r;
        conv_count_r <= conv_count_r;
      end
    end
  end

  assign bus.req_ready_o    = req_ready_s;
  assign bus.fp_valid_o     = (state_r == FULL);
  assign bus.fp_o           = fp_r;
  assign bus.fp_id_o        = fp_id_r;
  assign bus.fp_range_err_o = fp_err_r;
  assign bus.conv_count_o   = conv_count_r;

endmodule
